// File: rtl/dcpu_mem_ctrl.sv
// rtl/dcpu_mem_ctrl.sv - DCPU memory-side responder: imem/dmem, host load port, run/halt sequencing
//
// Purpose: owns the DCPU instruction and data memories, serves the core's
// fetch and data ports with zero-latency reads, lets a host fill memory while
// the core is stopped, and sequences LOAD -> RUN -> DONE with a cycle counter.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   HostValid/HostReady host write handshake (accepted in LOAD and DONE only)
//   HostSel             0 = instruction memory, 1 = data memory
//   HostAddr/HostData   host word address / write data
//   HostGo              start or restart a run (single-cycle pulse)
//   HostRdData          registered host readback (0 unless readback is built)
//   InstMemAddr/Inst    CPU fetch address / instruction word
//   DataMemAddr/DataMemWE/DataOut/DataIn  CPU data port
//   CpuEn, CpuStart     core EN and Start
//   Done                run ended on a HALT fetch
//   CycleCount          cycles spent in RUN, saturating
//
// Optional feature macro: DCPU_MEM_READBACK_EN (registered host readback mux).

module dcpu_mem_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HostValid,
  output logic              HostReady,
  input  logic              HostSel,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostData,
  input  logic              HostGo,
  output logic [DATA_W-1:0] HostRdData,
  input  logic [ADDR_W-1:0] InstMemAddr,
  output logic [DATA_W-1:0] Inst,
  input  logic [ADDR_W-1:0] DataMemAddr,
  input  logic              DataMemWE,
  input  logic [DATA_W-1:0] DataOut,
  output logic [DATA_W-1:0] DataIn,
  output logic              CpuEn,
  output logic              CpuStart,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  typedef enum logic [1:0] {LOAD, RUN, DONE} stateT;

  stateT state, nextState;

  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic        instInRange, dataInRange, hostInImem, hostInDmem;
  logic        hostWrite, cpuWrite, isHalt, startRun;
  logic        cpuStartQ;
  logic [15:0] cycleCountQ;

  // Out-of-range addresses read as zero and are never written.
  assign instInRange = 32'(InstMemAddr) < IMEM_DEPTH;
  assign dataInRange = 32'(DataMemAddr) < DMEM_DEPTH;
  assign hostInImem  = 32'(HostAddr) < IMEM_DEPTH;
  assign hostInDmem  = 32'(HostAddr) < DMEM_DEPTH;

  assign Inst   = instInRange ? imem[InstMemAddr] : '0;
  assign DataIn = dataInRange ? dmem[DataMemAddr] : '0;

  assign hostWrite = HostValid && HostReady;
  assign cpuWrite  = (state == RUN) && DataMemWE && dataInRange;
  assign isHalt    = (state == RUN) && (Inst[15:11] == 5'b00001);
  // HostGo only matters while the core is stopped.
  assign startRun  = (state != RUN) && HostGo;

  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    HostReady = 1'b1;
    CpuEn     = 1'b0;
    Done      = 1'b0;
    case (state)
      LOAD: begin
        if (HostGo) nextState = RUN;
      end
      RUN: begin
        HostReady = 1'b0;
        CpuEn     = 1'b1;
        if (isHalt) nextState = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (HostGo) nextState = RUN;
      end
      default: nextState = LOAD;
    endcase
  end

  // CpuStart marks only the first RUN cycle; the HALT cycle itself is counted
  // because the increment happens on the same edge that leaves RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cpuStartQ   <= 1'b0;
      cycleCountQ <= 16'h0000;
    end else begin
      cpuStartQ <= startRun;
      if (startRun)
        cycleCountQ <= 16'h0000;
      else if (state == RUN && cycleCountQ != 16'hFFFF)
        cycleCountQ <= cycleCountQ + 16'h0001;
    end
  end

  assign CpuStart   = cpuStartQ;
  assign CycleCount = cycleCountQ;

  // Memories are deliberately outside the reset domain so a reset keeps the
  // loaded program. Host and CPU writes are exclusive by state.
  always_ff @(posedge CLK) begin
    if (hostWrite && !HostSel && hostInImem) imem[HostAddr] <= HostData;
  end

  always_ff @(posedge CLK) begin
    if (hostWrite && HostSel && hostInDmem) dmem[HostAddr] <= HostData;
    else if (cpuWrite)                      dmem[DataMemAddr] <= DataOut;
  end

`ifdef DCPU_MEM_READBACK_EN
  logic [DATA_W-1:0] hostRdQ;

  // Sampled while the host owns memory, frozen during a run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hostRdQ <= '0;
    end else if (state != RUN) begin
      if (HostSel) hostRdQ <= hostInDmem ? dmem[HostAddr] : '0;
      else         hostRdQ <= hostInImem ? imem[HostAddr] : '0;
    end
  end

  assign HostRdData = hostRdQ;
`else
  assign HostRdData = '0;
`endif

endmodule

// File: tb/tb_dcpu_mem_ctrl.sv
// tb/tb_dcpu_mem_ctrl.sv - scoreboard bench for dcpu_mem_ctrl with a behavioural memory/run model

module tb_dcpu_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST, HostValid, HostSel, HostGo, DataMemWE;
  logic [7:0]  HostAddr, InstMemAddr, DataMemAddr;
  logic [15:0] HostData, DataOut;
  logic        HostReady, CpuEn, CpuStart, Done;
  logic [15:0] Inst, DataIn, HostRdData, CycleCount;

  dcpu_mem_ctrl dut (
    .CLK(CLK), .RST(RST),
    .HostValid(HostValid), .HostReady(HostReady), .HostSel(HostSel),
    .HostAddr(HostAddr), .HostData(HostData), .HostGo(HostGo),
    .HostRdData(HostRdData),
    .InstMemAddr(InstMemAddr), .Inst(Inst),
    .DataMemAddr(DataMemAddr), .DataMemWE(DataMemWE),
    .DataOut(DataOut), .DataIn(DataIn),
    .CpuEn(CpuEn), .CpuStart(CpuStart), .Done(Done), .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        hostReady, cpuEn, cpuStart, done, chkMem;
    logic [15:0] inst, dataIn, rdData, cycleCount;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;
  bit  monOn  = 1'b0;

  // Reference model: phase 0 = stopped/loading, 1 = running, 2 = finished.
  logic [15:0] mImem [256];
  logic [15:0] mDmem [256];
  int          mPhase = 0;
  int          mCnt   = 0;
  bit          mStart = 1'b0;
  logic [15:0] mRd    = 16'h0000;
  bit          memKnown = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (monOn) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        expT e;
        e = expQ.pop_front();
        chk("HostReady", 16'(HostReady), 16'(e.hostReady));
        chk("CpuEn", 16'(CpuEn), 16'(e.cpuEn));
        chk("CpuStart", 16'(CpuStart), 16'(e.cpuStart));
        chk("Done", 16'(Done), 16'(e.done));
        chk("CycleCount", CycleCount, e.cycleCount);
        if (e.chkMem) begin
          chk("Inst", Inst, e.inst);
          chk("DataIn", DataIn, e.dataIn);
          chk("HostRdData", HostRdData, e.rdData);
        end
      end
    end
  end

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance
  // the model by the controller's rules at the edge.
  task automatic step(input bit rst, input bit hv, input bit sel, input bit go, input bit we,
                      input logic [7:0] ha, input logic [7:0] ia, input logic [7:0] da,
                      input logic [15:0] hd, input logic [15:0] dout);
    expT         e;
    logic [15:0] newRd;
    logic [15:0] fetched;
    bit          halt;
    RST = rst; HostValid = hv; HostSel = sel; HostGo = go; DataMemWE = we;
    HostAddr = ha; InstMemAddr = ia; DataMemAddr = da; HostData = hd; DataOut = dout;
    e.hostReady  = (mPhase != 1);
    e.cpuEn      = (mPhase == 1);
    e.done       = (mPhase == 2);
    e.cpuStart   = mStart;
    e.cycleCount = 16'(mCnt);
    e.inst       = mImem[ia];
    e.dataIn     = mDmem[da];
    e.rdData     = mRd;
    e.chkMem     = memKnown;
    expQ.push_back(e);
    @(posedge CLK);
    newRd = mRd;
`ifdef DCPU_MEM_READBACK_EN
    if (mPhase != 1) newRd = sel ? mDmem[ha] : mImem[ha];
`endif
    fetched = mImem[ia];
    halt = (mPhase == 1) && (fetched[15:11] == 5'b00001);
    if (mPhase != 1 && hv) begin
      if (sel) mDmem[ha] = hd;
      else     mImem[ha] = hd;
    end
    if (mPhase == 1 && we) mDmem[da] = dout;
    if (rst) begin
      mPhase = 0; mCnt = 0; mStart = 1'b0; mRd = 16'h0000;
    end else begin
      mRd = newRd;
      mStart = 1'b0;
      if (mPhase == 1) begin
        if (mCnt < 65535) mCnt++;
        if (halt) mPhase = 2;
      end else if (go) begin
        mPhase = 1; mCnt = 0; mStart = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] ia, input logic [7:0] da, input logic [7:0] ha, input bit sel);
    step(0, 0, sel, 0, 0, ha, ia, da, 16'h0, 16'h0);
  endtask

  initial begin
    RST = 1'b1; HostValid = 1'b0; HostSel = 1'b0; HostGo = 1'b0; DataMemWE = 1'b0;
    HostAddr = 8'h0; InstMemAddr = 8'h0; DataMemAddr = 8'h0; HostData = 16'h0; DataOut = 16'h0;
    @(posedge CLK);
    #1;
    monOn = 1'b1;

    // Fill both memories so the model knows every word; avoid HALT codes so
    // runs stay long enough to exercise the counter.
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:11] == 5'b00001) w[15] = 1'b1;
      step(0, 1, 0, 0, 0, 8'(i), 8'h0, 8'h0, w, 16'h0);
    end
    for (int i = 0; i < 256; i++)
      step(0, 1, 1, 0, 0, 8'(i), 8'h0, 8'h0, 16'($urandom), 16'h0);
    idle(8'h0, 8'h0, 8'h0, 0);
    memKnown = 1'b1;

    // Reset values
    step(1, 0, 0, 0, 0, 8'h0, 8'h0, 8'h0, 16'h0, 16'h0);
    idle(8'h0, 8'h0, 8'h0, 0);

    // Host load and immediate readback through the CPU ports
    step(0, 1, 0, 0, 0, 8'h03, 8'h03, 8'h00, 16'hABCD, 16'h0);
    idle(8'h03, 8'h00, 8'h03, 0);
    step(0, 1, 1, 0, 0, 8'h00, 8'h03, 8'h00, 16'h0009, 16'h0);
    idle(8'h03, 8'h00, 8'h00, 1);
    step(0, 1, 0, 0, 0, 8'h27, 8'h03, 8'h00, 16'h0800, 16'h0);

    // DataMemWE in LOAD must not write
    step(0, 0, 0, 0, 1, 8'h00, 8'h03, 8'h02, 16'h0, 16'h5555);
    idle(8'h03, 8'h02, 8'h00, 0);

    // Go with a simultaneous host write
    step(0, 1, 1, 1, 0, 8'h05, 8'h03, 8'h05, 16'h7777, 16'h0);
    step(0, 1, 0, 0, 0, 8'h03, 8'h03, 8'h05, 16'h1111, 16'h0);
    step(0, 0, 0, 1, 1, 8'h00, 8'h03, 8'h02, 16'h0, 16'h000B);
    for (int i = 0; i < 8; i++) idle(8'h03, 8'h02, 8'h00, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h27, 8'h02, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) idle(8'h27, 8'h02, 8'h03, 0);

    // DONE: CPU writes ignored, host still owns memory, restart
    step(0, 0, 0, 0, 1, 8'h03, 8'h03, 8'h02, 16'h0, 16'h1234);
    step(0, 1, 1, 0, 0, 8'h06, 8'h03, 8'h06, 16'h4242, 16'h0);
    step(0, 0, 0, 1, 0, 8'h03, 8'h03, 8'h06, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) idle(8'h03, 8'h02, 8'h03, 0);

    // Reset mid-run keeps memory
    step(1, 0, 0, 0, 0, 8'h03, 8'h03, 8'h02, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) idle(8'h03, 8'h00, 8'h03, 0);

    // Randomized traffic; halts come from the 0x27 word or fresh writes.
    for (int i = 0; i < 3000; i++) begin
      bit          rst, hv, sel, go, we;
      logic [7:0]  ia;
      rst = ($urandom_range(0, 199) == 0);
      hv  = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 1) == 1;
      go  = ($urandom_range(0, 15) == 0);
      we  = $urandom_range(0, 1) == 1;
      ia  = ($urandom_range(0, 19) == 0) ? 8'h27 : 8'($urandom);
      step(rst, hv, sel, go, we, 8'($urandom), ia, 8'($urandom), 16'($urandom), 16'($urandom));
    end

    monOn = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcpu_mem_ctrl.md
Name: dcpu_mem_ctrl

Overview:
Memory-side responder for the DCPU core: owns instruction and data memory, answers the core's InstMemAddr/Inst and DataMemAddr/DataMemWE/DataOut/DataIn interface, and drives the core's EN/Start.
A host load port fills memory before a run.
A run/halt state machine sequences load, run and done phases and counts run cycles.
Sits between the DCPU core and the board-level host/loader.

Parameters:
ADDR_W, 8, width of instruction and data addresses
DATA_W, 16, width of instruction and data words
IMEM_DEPTH, 256, instruction memory words (at most 2**ADDR_W)
DMEM_DEPTH, 256, data memory words (at most 2**ADDR_W)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset; synchronous, active-high
HostValid  input  1  host write request
HostReady  output  1  controller accepts host writes this cycle
HostSel  input  1  0 = instruction memory, 1 = data memory
HostAddr  input  ADDR_W  host word address
HostData  input  DATA_W  host write data
HostGo  input  1  start/restart CPU run (single-cycle pulse)
HostRdData  output  DATA_W  host readback data (optional feature)
InstMemAddr  input  ADDR_W  CPU fetch address
Inst  output  DATA_W  instruction word to CPU
DataMemAddr  input  ADDR_W  CPU data address
DataMemWE  input  1  CPU data write enable
DataOut  input  DATA_W  CPU write data
DataIn  output  DATA_W  read data to CPU
CpuEn  output  1  drives core EN
CpuStart  output  1  drives core Start
Done  output  1  CPU fetched HALT; run finished
CycleCount  output  16  RUN-state cycle counter

Behaviour:
- States: LOAD, RUN, DONE. Reset state is LOAD.
- Reset values: HostReady=1, CpuEn=0, CpuStart=0, Done=0, CycleCount=0, HostRdData=0.
- RST does not clear memory contents. RST asserted in any state returns to LOAD at the next edge.
- Reads:
  - Inst = imem[InstMemAddr] and DataIn = dmem[DataMemAddr], combinational (zero latency).
  - Addresses >= DEPTH read 0.
- Writes are synchronous and take effect at the edge; readable the following cycle.
  - Writes to addresses >= DEPTH are dropped.
- HostReady=1 in LOAD and DONE, 0 in RUN.
  - Host write occurs when HostValid && HostReady.
  - HostValid in RUN is ignored, not queued.
- CPU write occurs only in RUN when DataMemWE=1. DataMemWE is ignored in LOAD and DONE.
- LOAD/DONE -> RUN on HostGo:
  - CycleCount cleared to 0 and CpuEn=1 from the next cycle.
  - CpuStart=1 for exactly the first RUN cycle, then 0.
  - Done cleared.
- HostValid and HostGo in the same cycle: the write is performed, then RUN is entered.
- RUN:
  - CycleCount increments by 1 each cycle, saturating at 16'hFFFF.
  - HostGo in RUN is ignored.
- RUN -> DONE when Inst[15:11]==5'b00001 (HALT) while in RUN.
  - Next cycle: CpuEn=0, Done=1, CycleCount frozen (the HALT cycle is counted).
- DONE holds until HostGo or RST. Memory stays host-readable and host-writable in DONE.

Optional Feature:
Macro DCPU_MEM_READBACK_EN.
- Defined: HostRdData is registered with 1-cycle latency.
  - Source: imem[HostAddr] when HostSel=0, dmem[HostAddr] when HostSel=1.
  - Updated every cycle in LOAD/DONE, held in RUN.
- Undefined: HostRdData is constant 0 and no readback mux is built.

Test Plan:
- Reset: RST=1 for one edge -> HostReady=1, CpuEn=0, CpuStart=0, Done=0, CycleCount=0, state LOAD.
- Host load: write imem[0x03]=16'hABCD (HostSel=0, HostValid=1), then InstMemAddr=0x03 -> Inst=16'hABCD. Write dmem[0x00]=16'h0009; DataMemAddr=0x00 -> DataIn=16'h0009.
- Start: HostGo pulse -> next cycle CpuEn=1, CpuStart=1 for exactly one cycle, HostReady=0. HostValid write to imem[0x03]=16'h1111 in RUN leaves 16'hABCD.
- CPU write: in RUN, DataMemWE=1, DataMemAddr=0x02, DataOut=16'h000B -> next cycle DataIn=16'h000B at address 0x02. Same stimulus in LOAD leaves dmem[0x02] unchanged.
- Halt: imem[0x27]=16'h0800, run 10 cycles, then InstMemAddr=0x27 -> next cycle Done=1, CpuEn=0, CycleCount=11 and stable. A further HostGo -> CycleCount=0, Done=0, RUN.
- Reset mid-run: RST during RUN -> LOAD next edge, outputs at reset values, imem[0x03] still 16'hABCD. With DCPU_MEM_READBACK_EN: HostSel=0, HostAddr=0x03 -> HostRdData=16'hABCD one cycle later.
